alu_seq_unit: RTL

Iterative multi-cycle arithmetic unit sitting directly downstream of the ALU B operand mux. It consumes `ALUA_DATA` and `ALUB_DATA` (the mux output) and performs 16x16 unsigned multiply, 16/16 unsigned divide, and multi-bit logical shifts, one bit per clock. The control sequencer uses a START/BUSY/DONE handshake and stalls until DONE.

---
 rtl/alu_seq_unit_pkg.sv | 19 +
 rtl/alu_seq_unit_if.sv | 28 ++
 rtl/alu_seq_datapath.sv | 83 ++++++++
 rtl/alu_seq_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_seq_unit_pkg.sv
// alu_seq_unit_pkg: shared constants for the iterative multiply/divide/shift unit.
// Holds the OP encodings driven by the control sequencer and the FSM state codes.
package alu_seq_unit_pkg;

    localparam logic [1:0] ALUX_OP_MULU = 2'b00;
    localparam logic [1:0] ALUX_OP_DIVU = 2'b01;
    localparam logic [1:0] ALUX_OP_LSLN = 2'b10;
    localparam logic [1:0] ALUX_OP_LSRN = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    // Both shift encodings have OP[1] set.
    function automatic logic op_is_shift(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: START/BUSY/DONE handshake plus operand and result bus.
//   master : control sequencer side (drives START, OP, operands)
//   slave  : alu_seq_unit side (drives BUSY, DONE, results, flags)
interface alu_seq_unit_if #(parameter int WIDTH = 16);

    logic             START;
    logic [1:0]       OP;
    logic [WIDTH-1:0] ALUA_DATA;
    logic [WIDTH-1:0] ALUB_DATA;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RES_LO;
    logic [WIDTH-1:0] RES_HI;
    logic             ZERO;
    logic             CARRY;
    logic             DIVZ;

    modport master (
        output START, OP, ALUA_DATA, ALUB_DATA,
        input  BUSY, DONE, RES_LO, RES_HI, ZERO, CARRY, DIVZ
    );

    modport slave (
        input  START, OP, ALUA_DATA, ALUB_DATA,
        output BUSY, DONE, RES_LO, RES_HI, ZERO, CARRY, DIVZ
    );

endinterface

// File: rtl/alu_seq_datapath.sv
// alu_seq_datapath: latched operands, 2*WIDTH accumulator/shift register and
// the single-step logic for each OP.
//   clk, rst_n : clock, async active-low reset
//   load       : latch op_in/a_in/b_in and initialise the accumulator
//   step       : perform one iteration (acc <= acc_nxt)
//   op         : latched operation
//   acc_nxt    : accumulator value after the current iteration
//   cout_nxt   : bit shifted out by the current iteration (shifts only)
module alu_seq_datapath
    import alu_seq_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [1:0]         op_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [1:0]         op,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               cout_nxt
);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     sum;     // shared adder/subtractor, one bit wider than operands

    assign op = op_q;

    always_comb begin
        rem_sh   = '0;
        sum      = '0;
        acc_nxt  = acc;
        cout_nxt = 1'b0;
        case (op_q)
            // acc = {partial product, remaining multiplier bits}; add A on the
            // multiplier LSB, then shift the whole thing right with the adder carry.
            ALUX_OP_MULU: begin
                sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
                acc_nxt = {sum, acc[WIDTH-1:1]};
            end
            // acc = {remainder, quotient}; sum[WIDTH] is the borrow of the trial subtract.
            ALUX_OP_DIVU: begin
                rem_sh = acc[2*WIDTH-1:WIDTH-1];
                sum    = rem_sh - {1'b0, b_q};
                if (!sum[WIDTH])
                    acc_nxt = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
            ALUX_OP_LSLN: begin
                acc_nxt  = {{WIDTH{1'b0}}, acc[WIDTH-2:0], 1'b0};
                cout_nxt = acc[WIDTH-1];
            end
            default: begin
                acc_nxt  = {{WIDTH{1'b0}}, 1'b0, acc[WIDTH-1:1]};
                cout_nxt = acc[0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= ALUX_OP_MULU;
            acc  <= '0;
        end else if (load) begin
            a_q  <= a_in;
            b_q  <= b_in;
            op_q <= op_in;
            acc  <= (op_in == ALUX_OP_MULU) ? {{WIDTH{1'b0}}, b_in} : {{WIDTH{1'b0}}, a_in};
        end else if (step) begin
            acc  <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: iterative MULU / DIVU / LSLN / LSRN unit, one bit per clock.
//   CLK    : system clock, rising edge
//   RESETN : async active-low reset; aborts any operation in flight
//   bus    : slave side of alu_seq_unit_if (START/OP/operands in,
//            BUSY/DONE/RES_LO/RES_HI/ZERO/CARRY/DIVZ out, all registered)
// Holds the FSM, iteration counter, result and flag registers.
module alu_seq_unit
    import alu_seq_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          CLK,
    input  logic          RESETN,
    alu_seq_unit_if.slave bus
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               busy, done, zero, carry, divz;
    logic [WIDTH-1:0]   res_lo, res_hi;

    logic               accept, div_by_zero, shift_by_zero, last;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               cout_nxt;

    assign accept        = bus.START && (state != ST_RUN);
    assign div_by_zero   = (bus.OP == ALUX_OP_DIVU) && (bus.ALUB_DATA == '0);
    assign shift_by_zero = op_is_shift(bus.OP) && (bus.ALUB_DATA[SW-1:0] == '0);
    assign last          = (state == ST_RUN) && (cnt == CW'(1));

    alu_seq_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (CLK),
        .rst_n    (RESETN),
        .load     (accept),
        .step     (state == ST_RUN),
        .op_in    (bus.OP),
        .a_in     (bus.ALUA_DATA),
        .b_in     (bus.ALUB_DATA),
        .op       (op_q),
        .acc_nxt  (acc_nxt),
        .cout_nxt (cout_nxt)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            divz   <= 1'b0;
        end else if (accept) begin
            done  <= 1'b0;
            zero  <= 1'b0;
            carry <= 1'b0;
            divz  <= 1'b0;
            cnt   <= op_is_shift(bus.OP) ? {1'b0, bus.ALUB_DATA[SW-1:0]} : CW'(WIDTH);
            // Zero-iteration cases finish on the accept edge itself.
            if (div_by_zero) begin
                state  <= ST_FIN;
                busy   <= 1'b0;
                done   <= 1'b1;
                res_lo <= '1;
                res_hi <= bus.ALUA_DATA;
                divz   <= 1'b1;
            end else if (shift_by_zero) begin
                state  <= ST_FIN;
                busy   <= 1'b0;
                done   <= 1'b1;
                res_lo <= bus.ALUA_DATA;
                res_hi <= '0;
                zero   <= (bus.ALUA_DATA == '0);
            end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
            end
        end else if (state == ST_RUN) begin
            cnt <= cnt - CW'(1);
            if (op_is_shift(op_q))
                carry <= cout_nxt;
            if (last) begin
                state  <= ST_FIN;
                busy   <= 1'b0;
                done   <= 1'b1;
                res_lo <= acc_nxt[WIDTH-1:0];
                res_hi <= acc_nxt[2*WIDTH-1:WIDTH];
                // MULU tests the full product; DIVU and shifts only the low half.
                zero   <= (op_q == ALUX_OP_MULU) ? (acc_nxt == '0) : (acc_nxt[WIDTH-1:0] == '0);
            end
        end
    end

    assign bus.BUSY   = busy;
    assign bus.DONE   = done;
    assign bus.RES_LO = res_lo;
    assign bus.RES_HI = res_hi;
    assign bus.ZERO   = zero;
    assign bus.CARRY  = carry;
    assign bus.DIVZ   = divz;

endmodule
